pipeline_hazard_ctrl: RTL and testbench

Parametrised hazard and stall controller for the five-stage pipelined CPU, sitting between the ID stage, the EX-stage multi-cycle unit and the MEM-stage data cache. It combines load-use detection, multi-cycle EX occupancy (counter-driven FSM), cache-miss pipeline freeze and ID-branch flush gating into one prioritised set of pipeline-register controls. It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Prioritised hazard/stall controller for a five-stage pipeline.
//            Combines data-cache freeze, multi-cycle EX occupancy, load-use
//            detection and ID branch flush gating into one set of pipeline
//            register controls, plus a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 3,
  parameter int PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] RS1,
  input  logic [REG_AW-1:0] RS2,
  input  logic              RS1_use,
  input  logic              RS2_use,
  input  logic [REG_AW-1:0] ID_EX_Rd,
  input  logic              ID_EX_MR,
  input  logic              ID_EX_MC,
  input  logic              mem_stall_i,
  input  logic              branch_taken_i,
  output logic              PC_write,
  output logic              IF_ID_write,
  output logic              IF_ID_flush,
  output logic              ID_EX_write,
  output logic              No_Op,
  output logic              EX_MEM_bubble,
  output logic              Freeze,
  output logic [PERF_W-1:0] stall_cycles_o
);

  // Multi-cycle ops only stall when they need more than one EX cycle.
  localparam logic             c_MC_EN    = (MC_LAT > 1);
  // Remaining stall cycles once the op has spent its first cycle in RUN.
  localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'((MC_LAT > 1) ? (MC_LAT - 2) : 0);
  localparam logic [PERF_W-1:0] c_PERF_MAX = {PERF_W{1'b1}};

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [PERF_W-1:0] r_stall_cycles;

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_lu;
  logic w_mc_stall;

  // Load-use: EX holds a load whose destination is a live, non-zero source in ID.
  assign w_rs1_hit  = RS1_use && (RS1 != '0) && (RS1 == ID_EX_Rd);
  assign w_rs2_hit  = RS2_use && (RS2 != '0) && (RS2 == ID_EX_Rd);
  assign w_lu       = ID_EX_MR && (w_rs1_hit || w_rs2_hit);

  // Stall while the multi-cycle op has not yet reached its final EX cycle.
  assign w_mc_stall = ((r_state == ST_RUN) && ID_EX_MC && c_MC_EN) ||
                      ((r_state == ST_MC_WAIT) && (r_cnt != '0));

  // Prioritised pipeline controls; reset forces the free-running defaults.
  always_comb begin
    PC_write      = 1'b1;
    IF_ID_write   = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_write   = 1'b1;
    No_Op         = 1'b0;
    EX_MEM_bubble = 1'b0;
    Freeze        = 1'b0;
    if (!rst_i) begin
      if (mem_stall_i) begin
        Freeze      = 1'b1;
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        ID_EX_write = 1'b0;
      end else if (w_mc_stall) begin
        PC_write      = 1'b0;
        IF_ID_write   = 1'b0;
        ID_EX_write   = 1'b0;
        EX_MEM_bubble = 1'b1;
      end else if (w_lu && (r_state == ST_RUN)) begin
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        No_Op       = 1'b1;
      end else if (branch_taken_i) begin
        // Only reached when ID is released, so a held branch flushes later.
        IF_ID_flush = 1'b1;
      end
    end
  end

  // Occupancy FSM: advances only on unfrozen cycles, reset abandons the op.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else if (!mem_stall_i) begin
      case (r_state)
        ST_RUN: begin
          if (ID_EX_MC && c_MC_EN) begin
            r_state <= ST_MC_WAIT;
            r_cnt   <= c_CNT_INIT;
          end
        end
        ST_MC_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held, whatever the cause.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cycles <= '0;
    end else if (!PC_write && (r_stall_cycles != c_PERF_MAX)) begin
      r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

  assign stall_cycles_o = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Directed vector table plus hand-written multi-cycle sequences
//            for pipeline_hazard_ctrl (MC_LAT=4 main instance, plus MC_LAT=1
//            and PERF_W=4 instances sharing the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam logic [6:0] c_IDLE  = 7'b1101000;
  localparam logic [6:0] c_LU    = 7'b0001100;
  localparam logic [6:0] c_FLUSH = 7'b1111000;
  localparam logic [6:0] c_FRZ   = 7'b0000001;
  localparam logic [6:0] c_MC    = 7'b0000010;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, mc, ms, br;

  logic        pc_w, ifid_w, ifid_f, idex_w, noop, bub, frz;
  logic [31:0] cnt_main;
  logic        l1_pc_w, l1_ifid_w, l1_ifid_f, l1_idex_w, l1_noop, l1_bub, l1_frz;
  logic [31:0] cnt_l1;
  logic        p4_pc_w, p4_ifid_w, p4_ifid_f, p4_idex_w, p4_noop, p4_bub, p4_frz;
  logic [3:0]  cnt_p4;
  logic [6:0]  w_out;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       mc;
    logic       ms;
    logic       br;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  assign w_out = {pc_w, ifid_w, ifid_f, idex_w, noop, bub, frz};

  pipeline_hazard_ctrl #(.REG_AW(5), .MC_LAT(4), .CNT_W(3), .PERF_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .RS1(rs1), .RS2(rs2), .RS1_use(u1), .RS2_use(u2),
    .ID_EX_Rd(rd), .ID_EX_MR(mr), .ID_EX_MC(mc), .mem_stall_i(ms), .branch_taken_i(br),
    .PC_write(pc_w), .IF_ID_write(ifid_w), .IF_ID_flush(ifid_f), .ID_EX_write(idex_w),
    .No_Op(noop), .EX_MEM_bubble(bub), .Freeze(frz), .stall_cycles_o(cnt_main)
  );

  pipeline_hazard_ctrl #(.REG_AW(5), .MC_LAT(1), .CNT_W(3), .PERF_W(32)) dut_l1 (
    .clk_i(clk), .rst_i(rst), .RS1(rs1), .RS2(rs2), .RS1_use(u1), .RS2_use(u2),
    .ID_EX_Rd(rd), .ID_EX_MR(mr), .ID_EX_MC(mc), .mem_stall_i(ms), .branch_taken_i(br),
    .PC_write(l1_pc_w), .IF_ID_write(l1_ifid_w), .IF_ID_flush(l1_ifid_f), .ID_EX_write(l1_idex_w),
    .No_Op(l1_noop), .EX_MEM_bubble(l1_bub), .Freeze(l1_frz), .stall_cycles_o(cnt_l1)
  );

  pipeline_hazard_ctrl #(.REG_AW(5), .MC_LAT(4), .CNT_W(3), .PERF_W(4)) dut_p4 (
    .clk_i(clk), .rst_i(rst), .RS1(rs1), .RS2(rs2), .RS1_use(u1), .RS2_use(u2),
    .ID_EX_Rd(rd), .ID_EX_MR(mr), .ID_EX_MC(mc), .mem_stall_i(ms), .branch_taken_i(br),
    .PC_write(p4_pc_w), .IF_ID_write(p4_ifid_w), .IF_ID_flush(p4_ifid_f), .ID_EX_write(p4_idex_w),
    .No_Op(p4_noop), .EX_MEM_bubble(p4_bub), .Freeze(p4_frz), .stall_cycles_o(cnt_p4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    rs1 = '0; rs2 = '0; rd = '0;
    u1 = 1'b0; u2 = 1'b0; mr = 1'b0; mc = 1'b0; ms = 1'b0; br = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    rs1 = v.rs1; rs2 = v.rs2; u1 = v.u1; u2 = v.u2; rd = v.rd;
    mr = v.mr; mc = v.mc; ms = v.ms; br = v.br;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [4:0] a, input logic [4:0] b, input logic ua,
                              input logic ub, input logic [4:0] d, input logic m_r,
                              input logic m_c, input logic m_s, input logic b_r,
                              input logic [6:0] e);
    vec_t v;
    v.rs1 = a; v.rs2 = b; v.u1 = ua; v.u2 = ub; v.rd = d;
    v.mr = m_r; v.mc = m_c; v.ms = m_s; v.br = b_r; v.exp = e;
    return v;
  endfunction

  initial begin
    //            rs1 rs2 u1 u2 rd mr mc ms br  expected
    tbl[0]  = mk(0,  0,  0, 0, 5, 0, 0, 0, 0, c_IDLE);
    tbl[1]  = mk(5,  0,  1, 0, 5, 1, 0, 0, 0, c_LU);
    tbl[2]  = mk(0,  0,  1, 0, 0, 1, 0, 0, 0, c_IDLE);
    tbl[3]  = mk(0,  5,  0, 0, 5, 1, 0, 0, 0, c_IDLE);
    tbl[4]  = mk(0,  5,  0, 1, 5, 1, 0, 0, 0, c_LU);
    tbl[5]  = mk(5,  0,  1, 0, 5, 0, 0, 0, 0, c_IDLE);
    tbl[6]  = mk(0,  0,  0, 0, 5, 0, 0, 0, 1, c_FLUSH);
    tbl[7]  = mk(5,  0,  1, 0, 5, 1, 0, 0, 1, c_LU);
    tbl[8]  = mk(5,  0,  1, 0, 5, 1, 0, 1, 1, c_FRZ);
    tbl[9]  = mk(0,  0,  0, 0, 5, 0, 1, 1, 0, c_FRZ);
    tbl[10] = mk(7,  0,  1, 0, 5, 1, 0, 0, 0, c_IDLE);
    tbl[11] = mk(0,  3,  0, 1, 3, 1, 0, 0, 0, c_LU);

    // Reset with hazard-looking inputs: outputs must still be the defaults.
    apply(mk(5, 5, 1, 1, 5, 1, 1, 1, 1, c_IDLE));
    #1;
    chk("reset_outputs", {25'd0, w_out}, {25'd0, c_IDLE});
    chk("reset_count", cnt_main, 32'd0);
    #1;
    rst = 1'b0;
    clr_in();
    step();

    // Single-cycle combinational vectors, all in RUN.
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), {25'd0, w_out}, {25'd0, tbl[i].exp});
      if (!tbl[i].exp[6]) exp_cnt++;
      step();
    end
    clr_in();
    @(negedge clk);
    chk("table_count", cnt_main, exp_cnt);
    step();

    // Two back-to-back multi-cycle ops: 3 stall cycles then release, twice.
    mc = 1'b1;
    for (int op = 0; op < 2; op++) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk($sformatf("mc_op%0d_stall%0d", op, k), {25'd0, w_out}, {25'd0, c_MC});
        if (k == 0) chk($sformatf("mclat1_op%0d_nostall", op), {31'd0, l1_pc_w}, 32'd1);
        step();
      end
      @(negedge clk);
      chk($sformatf("mc_op%0d_release", op), {25'd0, w_out}, {25'd0, c_IDLE});
      step();
    end
    mc = 1'b0;
    exp_cnt += 6;
    @(negedge clk);
    chk("mc_count", cnt_main, exp_cnt);
    chk("mc_idle_after", {25'd0, w_out}, {25'd0, c_IDLE});
    step();

    // Freeze for 5 cycles starting at occupancy cycle 2: 8 stall cycles total.
    mc = 1'b1;
    @(negedge clk);
    chk("frz_occ1", {25'd0, w_out}, {25'd0, c_MC});
    step();
    ms = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("frz_hold%0d", k), {25'd0, w_out}, {25'd0, c_FRZ});
      step();
    end
    ms = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("frz_resume%0d", k), {25'd0, w_out}, {25'd0, c_MC});
      step();
    end
    @(negedge clk);
    chk("frz_release", {25'd0, w_out}, {25'd0, c_IDLE});
    step();
    mc = 1'b0;
    exp_cnt += 8;
    @(negedge clk);
    chk("frz_count", cnt_main, exp_cnt);
    step();

    // Freeze arriving with the first multi-cycle cycle delays the FSM start.
    mc = 1'b1;
    ms = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("frz_first%0d", k), {25'd0, w_out}, {25'd0, c_FRZ});
      step();
    end
    ms = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("late_mc%0d", k), {25'd0, w_out}, {25'd0, c_MC});
      step();
    end
    @(negedge clk);
    chk("late_mc_release", {25'd0, w_out}, {25'd0, c_IDLE});
    step();
    mc = 1'b0;
    exp_cnt += 5;

    // Branch held behind a load-use stall flushes once ID is released.
    apply(mk(5, 0, 1, 0, 5, 1, 0, 0, 1, c_LU));
    @(negedge clk);
    chk("br_lu_noflush", {25'd0, w_out}, {25'd0, c_LU});
    step();
    mr = 1'b0;
    @(negedge clk);
    chk("br_flush_after", {25'd0, w_out}, {25'd0, c_FLUSH});
    step();
    clr_in();
    exp_cnt += 1;
    @(negedge clk);
    chk("br_count", cnt_main, exp_cnt);
    step();

    // Asynchronous reset in MC_WAIT with cnt=1.
    mc = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("rst_pre_mc%0d", k), {25'd0, w_out}, {25'd0, c_MC});
      step();
    end
    chk("rst_pre_cnt1", {25'd0, w_out}, {25'd0, c_MC});
    apply(mk(5, 0, 1, 0, 5, 1, 1, 1, 1, c_IDLE));
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_out", {25'd0, w_out}, {25'd0, c_IDLE});
    chk("rst_async_count", cnt_main, 32'd0);
    #1;
    rst = 1'b0;
    clr_in();
    @(negedge clk);
    chk("rst_after_run", {25'd0, w_out}, {25'd0, c_IDLE});
    chk("rst_after_count", cnt_main, 32'd0);
    step();

    // 20 freeze cycles: 4-bit counter saturates at 15, 32-bit one reaches 20.
    ms = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 15 || k == 20) begin
        chk($sformatf("sat_p4_at%0d", k), {28'd0, cnt_p4}, 32'd15);
        chk($sformatf("sat_main_at%0d", k), cnt_main, k);
      end
    end
    chk("sat_freeze_out", {25'd0, w_out}, {25'd0, c_FRZ});
    clr_in();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
